// File: rtl/disp_source_scheduler.sv
// -----------------------------------------------------------------------------
// disp_source_scheduler
//   Round-robin scheduler that shares a six-digit hex display between three
//   sources. A granted source stays on the display for at least DWELL_CYCLES
//   cycles, unless it drops its request first. While a source is granted, each
//   of its six hex nibbles is driven onto one digit output.
//
//   Optional feature macro: SCHED_FREEZE_EN (adds the freeze input, which holds
//   the whole schedule and the display contents while it is high).
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   req[2:0]      level-sensitive per-source display request
//   val0..val2    24-bit (six hex digit) value for source 0/1/2
//   freeze        display hold (SCHED_FREEZE_EN builds only)
//   data0..data5  digit values, data0 is the leftmost digit, upper nibble 0
//   gnt[2:0]      one-hot grant, zero when idle
//   active_src    index of the granted source, 0 when idle
//   switch_pulse  one-cycle pulse whenever a new source is granted
// -----------------------------------------------------------------------------
module disp_source_scheduler #(
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [23:0] val0,
  input  logic [23:0] val1,
  input  logic [23:0] val2,
`ifdef SCHED_FREEZE_EN
  input  logic        freeze,
`endif
  output logic [7:0]  data0,
  output logic [7:0]  data1,
  output logic [7:0]  data2,
  output logic [7:0]  data3,
  output logic [7:0]  data4,
  output logic [7:0]  data5,
  output logic [2:0]  gnt,
  output logic [1:0]  active_src,
  output logic        switch_pulse
);

  typedef enum logic {IDLE, SHOW} state_t;

  localparam logic [25:0] CNT_LAST = 26'(DWELL_CYCLES - 1);

  state_t          state, state_d;
  logic [1:0]      active_q, src_d;
  logic [1:0]      last_ptr, ptr_d;
  logic [25:0]     cnt, cnt_d;
  logic            sw_q, sw_d;
  logic [2:0]      gnt_q, gnt_d;
  logic [1:0]      active_d;
  logic [5:0][7:0] data_q, data_d;
  logic            frz;
  logic [2:0]      cur_mask;
  logic [2:0]      others;
  logic [23:0]     val_sel;

`ifdef SCHED_FREEZE_EN
  assign frz = freeze;
`else
  assign frz = 1'b0;
`endif

  // First set bit of r, scanning from (lp+1) mod 3 upward with wrap.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] lp);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = 2'd0;
    found = 1'b0;
    idx   = (lp == 2'd2) ? 2'd0 : lp + 2'd1;
    for (int unsigned i = 0; i < 3; i++) begin
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    return win;
  endfunction

  // State register (all outputs are registered here as well)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      active_q <= 2'd0;
      last_ptr <= 2'd2;
      cnt      <= '0;
      sw_q     <= 1'b0;
      gnt_q    <= '0;
      data_q   <= '0;
    end else begin
      state    <= state_d;
      active_q <= active_d;
      last_ptr <= ptr_d;
      cnt      <= cnt_d;
      sw_q     <= sw_d;
      gnt_q    <= gnt_d;
      data_q   <= data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state;
    src_d    = active_q;
    ptr_d    = last_ptr;
    cnt_d    = cnt;
    sw_d     = 1'b0;
    cur_mask = 3'(3'b001 << active_q);
    others   = req & ~cur_mask;
    if (!frz) begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            state_d = SHOW;
            src_d   = rr_pick(req, last_ptr);
            ptr_d   = src_d;
            cnt_d   = '0;
            sw_d    = 1'b1;
          end
        end
        SHOW: begin
          // last_ptr equals the current source here, so picking from
          // "others" starting after last_ptr excludes the current source.
          if (!(|(req & cur_mask))) begin
            if (|others) begin
              src_d = rr_pick(others, last_ptr);
              ptr_d = src_d;
              cnt_d = '0;
              sw_d  = 1'b1;
            end else begin
              state_d = IDLE;
              src_d   = 2'd0;
              cnt_d   = '0;
            end
          end else if (cnt == CNT_LAST) begin
            cnt_d = '0;
            if (|others) begin
              src_d = rr_pick(others, last_ptr);
              ptr_d = src_d;
              sw_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt + 26'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode from the next state
  always_comb begin
    gnt_d    = '0;
    active_d = 2'd0;
    data_d   = '0;
    val_sel  = '0;
    unique case (src_d)
      2'd0:    val_sel = val0;
      2'd1:    val_sel = val1;
      default: val_sel = val2;
    endcase
    if (frz) begin
      gnt_d    = gnt_q;
      active_d = active_q;
      data_d   = data_q;
    end else if (state_d == SHOW) begin
      gnt_d    = 3'(3'b001 << src_d);
      active_d = src_d;
      for (int unsigned k = 0; k < 6; k++) begin
        data_d[k] = {4'h0, val_sel[23 - 4*k -: 4]};
      end
    end
  end

  assign data0        = data_q[0];
  assign data1        = data_q[1];
  assign data2        = data_q[2];
  assign data3        = data_q[3];
  assign data4        = data_q[4];
  assign data5        = data_q[5];
  assign gnt          = gnt_q;
  assign active_src   = active_q;
  assign switch_pulse = sw_q;

endmodule

// File: tb/tb_disp_source_scheduler.sv
module tb_disp_source_scheduler;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [23:0] val0, val1, val2;
`ifdef SCHED_FREEZE_EN
  logic        freeze;
`endif
  logic [7:0]  data0, data1, data2, data3, data4, data5;
  logic [2:0]  gnt;
  logic [1:0]  active_src;
  logic        switch_pulse;

  int checks = 0;
  int errors = 0;

  disp_source_scheduler #(.DWELL_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .val0         (val0),
    .val1         (val1),
    .val2         (val2),
`ifdef SCHED_FREEZE_EN
    .freeze       (freeze),
`endif
    .data0        (data0),
    .data1        (data1),
    .data2        (data2),
    .data3        (data3),
    .data4        (data4),
    .data5        (data5),
    .gnt          (gnt),
    .active_src   (active_src),
    .switch_pulse (switch_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] expand(input logic [23:0] v);
    logic [47:0] r;
    for (int k = 0; k < 6; k++) r[47 - 8*k -: 8] = {4'h0, v[23 - 4*k -: 4]};
    return r;
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] dig();
    return {data0, data1, data2, data3, data4, data5};
  endfunction

  initial begin
    logic [1:0] s;
    rst_n = 1'b0;
    req   = 3'b000;
    val0  = 24'h123ABC;
    val1  = 24'h654321;
    val2  = 24'hFEDCBA;
`ifdef SCHED_FREEZE_EN
    freeze = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt", 48'(gnt), 48'h0);
    check("rst_act", 48'(active_src), 48'h0);
    check("rst_sw", 48'(switch_pulse), 48'h0);
    check("rst_data", dig(), 48'h0);

    // Single requester, first grant
    rst_n = 1'b1;
    req   = 3'b001;
    @(negedge clk);
    check("first_gnt", 48'(gnt), 48'h1);
    check("first_sw", 48'(switch_pulse), 48'h1);
    check("first_data", dig(), 48'h01020_30A0B0C);

    // Only req[0] held: grant kept through dwell expiry, data tracks val0
    for (int i = 1; i < 12; i++) begin
      if (i == 5) val0 = 24'h456DEF;
      @(negedge clk);
      check("solo_gnt", 48'(gnt), 48'h1);
      check("solo_sw", 48'(switch_pulse), 48'h0);
      check("solo_data", dig(), expand(val0));
    end
    check("solo_new", dig(), 48'h04050_60D0E0F);

    // Request drops: back to idle
    req = 3'b000;
    @(negedge clk);
    check("idle_gnt", 48'(gnt), 48'h0);
    check("idle_act", 48'(active_src), 48'h0);
    check("idle_data", dig(), 48'h0);

    // All requesting from reset: 0,1,2,0, each for 4 cycles
    rst_n = 1'b0;
    req   = 3'b111;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      s = 2'((i / 4) % 3);
      check("rr_gnt", 48'(gnt), 48'(3'(3'b001 << s)));
      check("rr_act", 48'(active_src), 48'(s));
      check("rr_sw", 48'(switch_pulse), 48'((i % 4) == 0));
      check("rr_data", dig(), expand(s == 2'd0 ? val0 : s == 2'd1 ? val1 : val2));
    end

    // Source 1 granted, drop to 101 at dwell count 1 -> source 2
    @(negedge clk);
    check("s1_gnt", 48'(gnt), 48'h2);
    check("s1_sw", 48'(switch_pulse), 48'h1);
    @(negedge clk);
    req = 3'b101;
    @(negedge clk);
    check("drop_gnt", 48'(gnt), 48'h4);
    check("drop_sw", 48'(switch_pulse), 48'h1);
    check("drop_data", dig(), expand(val2));

    // Reset mid-show with req=110
    req = 3'b110;
    @(negedge clk);
    check("pre_rst_gnt", 48'(gnt), 48'h4);
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", 48'(gnt), 48'h0);
    check("async_act", 48'(active_src), 48'h0);
    check("async_sw", 48'(switch_pulse), 48'h0);
    check("async_data", dig(), 48'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_gnt", 48'(gnt), 48'h2);
    check("post_rst_sw", 48'(switch_pulse), 48'h1);

`ifdef SCHED_FREEZE_EN
    // Freeze at dwell count 1 while source 0 is granted
    rst_n = 1'b0;
    req   = 3'b001;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("fz_start", 48'(gnt), 48'h1);
    @(negedge clk);
    freeze = 1'b1;
    req    = 3'b011;
    val0   = 24'h000000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("fz_gnt", 48'(gnt), 48'h1);
      check("fz_sw", 48'(switch_pulse), 48'h0);
      check("fz_data", dig(), 48'h04050_60D0E0F);
    end
    freeze = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("unfz_gnt", 48'(gnt), (i == 3) ? 48'h2 : 48'h1);
      check("unfz_sw", 48'(switch_pulse), 48'(i == 3));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
